mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Two-master arbiter for the single CPU memory bus (req/rec handshake): port I = L1 instruction line fill, port D = load/store/trap-vector fetch.
//  Sits between criscv core request logic and the SDRAM/memory controller.
//  Grants one master per transaction and keeps I-port grant for a whole cache-line burst.
//  Aborts hung transactions after a timeout.
// PARAMETERS
//  LINE_BEATS   8      max consecutive I-port beats kept under one grant (cache line words)
//  TIMEOUT      1023   cycles without mem_rec before abort; 10-bit counter, 0 disables
//  D_PRIORITY   1      1: D wins a simultaneous request at arbitration; 0: round-robin
// PORTS
//  mclk           in   1   clock
//  reset          in   1   asynchronous active-low reset
//  i_req/d_req    in   1   level request, held until i_rec/d_rec or i_err/d_err
//  i_addr/d_addr  in   32  byte address
//  i_rw/d_rw      in   1   0 read, 1 write
//  i_wdata/d_wdata in  32  write data
//  i_size/d_size  in   2   0 byte, 1 half, 2 word
//  i_rec/d_rec    out  1   1-cycle completion pulse; = mem_rec & owner
//  i_err/d_err    out  1   1-cycle timeout-abort pulse to owner
//  rdata          out  32  = mem_read_data (combinational, valid with *_rec)
//  mem_address    out  32  registered bus address
//  mem_rw_req     out  1   registered bus request
//  mem_rw         out  1   registered direction
//  mem_write_data out  32  registered write data
//  mem_size       out  2   registered size
//  mem_read_data  in   32  bus read data
//  mem_rec        in   1   bus completion
//  bus_timeout    out  1   sticky; set on any abort, cleared only by reset
// BEHAVIOUR
//  Reset (async, reset=0): state IDLE; all outputs 0; owner=NONE; beat_cnt=0; last_owner=D.
//  States: IDLE -> GRANT -> RELEASE -> IDLE.
//  IDLE: sample i_req/d_req. Winner selection:
//   - lock: last_owner=I, i_req=1, beat_cnt<LINE_BEATS-1 -> I keeps grant, beat_cnt++.
//   - else D_PRIORITY=1 -> D before I.
//   - else (D_PRIORITY=0) -> requester other than last_owner.
//   - On a new I grant (no lock), beat_cnt=0.
//   On a grant: latch winner's addr/rw/wdata/size into mem_*; set mem_rw_req=1; go to GRANT.
//   First grant latency: req seen cycle N -> mem_rw_req=1 at N+1.
//  GRANT: mem_* stable, timer counts up.
//   - mem_rec=1: owner *_rec=1 same cycle (combinational); mem_rw_req<=0; last_owner<=owner; go to RELEASE.
//   - timer==TIMEOUT, TIMEOUT!=0: owner *_err=1; mem_rw_req<=0; bus_timeout<=1; beat_cnt<=0; go to RELEASE.
//   - mem_rec and timeout in the same cycle: rec wins, no err.
//  RELEASE: one idle cycle, mem_rw_req=0 (lets bus slave drop rec); owner<=NONE; timer<=0; go to IDLE.
//   Back-to-back beats: rec at cycle M -> next mem_rw_req=1 at M+3.
//  Requesters may change addr/data only after *_rec; arbiter ignores port inputs outside IDLE.
//  A requester that drops req while granted does not abort the bus cycle; the rec pulse is still given, then the grant is released.
//  Lock is broken when i_req is low in IDLE. After LINE_BEATS beats, D (if requesting) is granted next.
//  Owner never changes while mem_rw_req=1.
//  mem_address and mem_rw_req change together on the same edge.
// STRUCTURE
//  Package mem_bus_pkg: size codes (SZ_BYTE/HALF/WORD), owner enum (OWN_NONE/I/D), state enum (ARB_IDLE/GRANT/RELEASE).
//  Single module. Timer and beat counter are inline; no sub-module needed.
// TESTING
//  1 d_req only, addr 0x100, slave rec after 3 cyc -> mem_rw_req@N+1, mem_address=0x100, d_rec 1 pulse, mem_rw_req low 1 cyc.
//  2 i_req and d_req together from idle, D_PRIORITY=1 -> D granted first, I next.
//    Same with D_PRIORITY=0, last_owner=D -> I granted first.
//  3 I line fill 0x40..0x5C, d_req raised after beat 2 -> I keeps 8 beats, D granted on 9th arbitration.
//    Run 9 I beats -> lock broken after 8, D granted.
//  4 slave never recs, TIMEOUT=16 -> *_err at cycle 16 of GRANT, bus_timeout=1, mem_rw_req=0, next requester served.
//  5 mem_rec coincident with timeout -> *_rec only, bus_timeout stays 0.
//  6 reset low mid-GRANT, write SW 0xDEADBEEF -> all outputs 0 asynchronously, IDLE after release, fresh grant works.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared encodings for the CPU memory-bus arbiter: access sizes, bus owner and FSM state.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_e;

    localparam int TIMER_W = 10;
    localparam int BEAT_W  = 8;

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-master (I-fill / D-access) arbiter for the single req/rec memory bus, with
// cache-line grant locking for the I port and a hung-transaction timeout.
module mem_port_arbiter
    import mem_bus_pkg::*;
#(
    parameter int LINE_BEATS = 8,
    parameter int TIMEOUT    = 1023,
    parameter bit D_PRIORITY = 1'b1
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic        i_req,
    input  logic        d_req,
    input  logic [31:0] i_addr,
    input  logic [31:0] d_addr,
    input  logic        i_rw,
    input  logic        d_rw,
    input  logic [31:0] i_wdata,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  i_size,
    input  logic [1:0]  d_size,
    output logic        i_rec,
    output logic        d_rec,
    output logic        i_err,
    output logic        d_err,
    output logic [31:0] rdata,
    output logic [31:0] mem_address,
    output logic        mem_rw_req,
    output logic        mem_rw,
    output logic [31:0] mem_write_data,
    output logic [1:0]  mem_size,
    input  logic [31:0] mem_read_data,
    input  logic        mem_rec,
    output logic        bus_timeout,
    output arb_state_e  dbg_state_o
);

    localparam logic [TIMER_W-1:0] TIMEOUT_C = TIMEOUT[TIMER_W-1:0];
    localparam logic [BEAT_W-1:0]  LOCK_LAST = BEAT_W'(LINE_BEATS - 1);

    arb_state_e         state_q, state_d;
    owner_e             owner_q, owner_d;
    owner_e             last_owner_q, last_owner_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [1:0]         size_q, size_d;
    logic               rw_q, rw_d;
    logic               rw_req_q, rw_req_d;
    logic               timeout_q, timeout_d;

    logic   lock;
    owner_e win;
    logic   grant_rec;
    logic   grant_abort;

    // The I port keeps the bus across consecutive beats of one cache-line fill.
    assign lock = (last_owner_q == OWN_I) && i_req && (beat_q < LOCK_LAST);

    always_comb begin
        win = OWN_NONE;
        if (lock) begin
            win = OWN_I;
        end else if (d_req && i_req) begin
            if (D_PRIORITY) begin
                win = OWN_D;
            end else begin
                win = (last_owner_q == OWN_D) ? OWN_I : OWN_D;
            end
        end else if (d_req) begin
            win = OWN_D;
        end else if (i_req) begin
            win = OWN_I;
        end
    end

    // A completion in the timeout cycle takes precedence, so the abort is masked by mem_rec.
    assign grant_rec   = (state_q == ARB_GRANT) && mem_rec;
    assign grant_abort = (state_q == ARB_GRANT) && (TIMEOUT_C != '0) &&
                         (timer_q == TIMEOUT_C) && !mem_rec;

    assign i_rec = grant_rec   && (owner_q == OWN_I);
    assign d_rec = grant_rec   && (owner_q == OWN_D);
    assign i_err = grant_abort && (owner_q == OWN_I);
    assign d_err = grant_abort && (owner_q == OWN_D);

    assign rdata          = mem_read_data;
    assign mem_address    = addr_q;
    assign mem_rw_req     = rw_req_q;
    assign mem_rw         = rw_q;
    assign mem_write_data = wdata_q;
    assign mem_size       = size_q;
    assign bus_timeout    = timeout_q;
    assign dbg_state_o    = state_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_d       = beat_q;
        timer_d      = timer_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        rw_d         = rw_q;
        rw_req_d     = rw_req_q;
        timeout_d    = timeout_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (win != OWN_NONE) begin
                    owner_d  = win;
                    rw_req_d = 1'b1;
                    timer_d  = '0;
                    state_d  = ARB_GRANT;
                    if (win == OWN_D) begin
                        addr_d  = d_addr;
                        rw_d    = d_rw;
                        wdata_d = d_wdata;
                        size_d  = d_size;
                    end else begin
                        addr_d  = i_addr;
                        rw_d    = i_rw;
                        wdata_d = i_wdata;
                        size_d  = i_size;
                        beat_d  = lock ? beat_q + 1'b1 : '0;
                    end
                end
            end
            ARB_GRANT: begin
                if (grant_rec) begin
                    rw_req_d     = 1'b0;
                    last_owner_d = owner_q;
                    state_d      = ARB_RELEASE;
                end else if (grant_abort) begin
                    rw_req_d  = 1'b0;
                    timeout_d = 1'b1;
                    beat_d    = '0;
                    state_d   = ARB_RELEASE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ARB_RELEASE: begin
                owner_d = OWN_NONE;
                timer_d = '0;
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWN_NONE;
            last_owner_q <= OWN_D;
            beat_q       <= '0;
            timer_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
            rw_q         <= 1'b0;
            rw_req_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_q       <= beat_d;
            timer_q      <= timer_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            rw_q         <= rw_d;
            rw_req_q     <= rw_req_d;
            timeout_q    <= timeout_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: main instance (D priority, short timeout) plus a
// round-robin instance with the timeout disabled.
module tb_mem_port_arbiter;
    import mem_bus_pkg::*;

    localparam int W = 69;  // {i_rec, d_rec, rw, size[1:0], wdata[31:0], addr[31:0]}

    logic        mclk;
    logic        reset;
    logic        i_req, d_req, i_rw, d_rw, mem_rec;
    logic [31:0] i_addr, d_addr, i_wdata, d_wdata, mem_read_data;
    logic [1:0]  i_size, d_size;
    logic        i_rec, d_rec, i_err, d_err, mem_rw_req, mem_rw, bus_timeout;
    logic [31:0] rdata, mem_address, mem_write_data;
    logic [1:0]  mem_size;
    arb_state_e  a_state;

    logic        b_i_req, b_d_req, b_mem_rec;
    logic [31:0] b_i_addr, b_d_addr;
    logic        b_i_rec, b_d_rec, b_i_err, b_d_err, b_mem_rw_req, b_mem_rw, b_bus_timeout;
    logic [31:0] b_rdata, b_mem_address, b_mem_write_data;
    logic [1:0]  b_mem_size;
    arb_state_e  b_state;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] cur;
    int n_checks = 0;
    int n_pass   = 0;

    mem_port_arbiter #(.LINE_BEATS(8), .TIMEOUT(16), .D_PRIORITY(1'b1)) dut_a (
        .mclk(mclk), .reset(reset),
        .i_req(i_req), .d_req(d_req), .i_addr(i_addr), .d_addr(d_addr),
        .i_rw(i_rw), .d_rw(d_rw), .i_wdata(i_wdata), .d_wdata(d_wdata),
        .i_size(i_size), .d_size(d_size),
        .i_rec(i_rec), .d_rec(d_rec), .i_err(i_err), .d_err(d_err), .rdata(rdata),
        .mem_address(mem_address), .mem_rw_req(mem_rw_req), .mem_rw(mem_rw),
        .mem_write_data(mem_write_data), .mem_size(mem_size),
        .mem_read_data(mem_read_data), .mem_rec(mem_rec),
        .bus_timeout(bus_timeout), .dbg_state_o(a_state)
    );

    mem_port_arbiter #(.LINE_BEATS(8), .TIMEOUT(0), .D_PRIORITY(1'b0)) dut_b (
        .mclk(mclk), .reset(reset),
        .i_req(b_i_req), .d_req(b_d_req), .i_addr(b_i_addr), .d_addr(b_d_addr),
        .i_rw(1'b0), .d_rw(1'b0), .i_wdata(32'h0), .d_wdata(32'h0),
        .i_size(2'd2), .d_size(2'd2),
        .i_rec(b_i_rec), .d_rec(b_d_rec), .i_err(b_i_err), .d_err(b_d_err), .rdata(b_rdata),
        .mem_address(b_mem_address), .mem_rw_req(b_mem_rw_req), .mem_rw(b_mem_rw),
        .mem_write_data(b_mem_write_data), .mem_size(b_mem_size),
        .mem_read_data(32'h0), .mem_rec(b_mem_rec),
        .bus_timeout(b_bus_timeout), .dbg_state_o(b_state)
    );

    // clock / reset
    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic [W-1:0] mk(input logic to_i, input logic rw, input logic [1:0] sz,
                                         input logic [31:0] wd, input logic [31:0] ad);
        return {to_i, ~to_i, rw, sz, wd, ad};
    endfunction

    // scoreboard: pop the expected transfer when the bus request rises
    task automatic wait_grant(input string tag);
        int n;
        n = 0;
        while (!mem_rw_req && n < 100) begin
            @(negedge mclk);
            n++;
        end
        if (!mem_rw_req) begin
            check({tag, "_grant_wait"}, W'(0), W'(1));
        end else if (exp_q.size() == 0) begin
            check({tag, "_unexpected_grant"}, W'(exp_q.size()), W'(1));
        end else begin
            cur = exp_q.pop_front();
            check({tag, "_bus"}, W'({mem_rw, mem_size, mem_write_data, mem_address}),
                  W'(cur[66:0]));
        end
    endtask

    // bus slave: completes the granted transfer in GRANT cycle 'lat'
    task automatic serve(input string tag, input int lat);
        logic [31:0] rd;
        wait_grant(tag);
        repeat (lat) @(posedge mclk);
        #1;
        rd            = $urandom();
        mem_read_data = rd;
        mem_rec       = 1'b1;
        @(negedge mclk);
        check({tag, "_rec"}, W'({i_rec, d_rec, i_err, d_err}), W'({cur[68:67], 2'b00}));
        check({tag, "_rdata"}, W'(rdata), W'(rd));
        @(posedge mclk);
        #1 mem_rec = 1'b0;
        @(negedge mclk);
        check({tag, "_release"}, W'({mem_rw_req, i_rec, d_rec}), W'(0));
    endtask

    // after serve returns (cycle M+1): low at M+2, re-granted at M+3
    task automatic check_gap(input string tag);
        @(negedge mclk);
        check({tag, "_gap_m2"}, W'(mem_rw_req), W'(0));
        @(negedge mclk);
        check({tag, "_gap_m3"}, W'(mem_rw_req), W'(1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, W'({mem_rw_req, mem_rw, mem_size, mem_write_data, mem_address,
                                  bus_timeout, i_rec, d_rec, i_err, d_err}), W'(0));
        check({tag, "_state"}, W'(a_state), W'(ARB_IDLE));
    endtask

    task automatic b_wait_grant(input string tag);
        int n;
        n = 0;
        while (!b_mem_rw_req && n < 100) begin
            @(negedge mclk);
            n++;
        end
        check({tag, "_grant"}, W'(b_mem_rw_req), W'(1));
    endtask

    initial begin
        logic saw_err;
        int lat;
        reset = 1'b0;
        {i_req, d_req, i_rw, d_rw, mem_rec} = '0;
        {i_addr, d_addr, i_wdata, d_wdata, mem_read_data} = '0;
        i_size = 2'd0;
        d_size = 2'd0;
        {b_i_req, b_d_req, b_mem_rec} = '0;
        b_i_addr = '0;
        b_d_addr = '0;

        repeat (2) @(posedge mclk);
        @(negedge mclk);
        check_all_zero("reset");
        reset = 1'b1;

        // single D read, latency and release
        @(posedge mclk);
        #1;
        d_addr = 32'h100; d_rw = 1'b0; d_size = 2'd2; d_wdata = 32'h0;
        exp_q.push_back(mk(1'b0, 1'b0, 2'd2, 32'h0, 32'h100));
        d_req = 1'b1;
        @(negedge mclk);
        check("t1_pre_grant", W'(mem_rw_req), W'(0));
        @(negedge mclk);
        check("t1_latency", W'(mem_rw_req), W'(1));
        serve("t1", 3);
        d_req = 1'b0;

        // simultaneous request, D priority
        @(posedge mclk);
        #1;
        i_addr = 32'h1000; i_rw = 1'b0; i_size = 2'd2; i_wdata = 32'h0;
        d_addr = 32'h2002; d_rw = 1'b1; d_size = 2'd1; d_wdata = $urandom();
        exp_q.push_back(mk(1'b0, 1'b1, 2'd1, d_wdata, 32'h2002));
        exp_q.push_back(mk(1'b1, 1'b0, 2'd2, 32'h0, 32'h1000));
        i_req = 1'b1;
        d_req = 1'b1;
        serve("t2_d", 2);
        d_req = 1'b0;
        serve("t2_i", 2);
        i_req = 1'b0;

        // mem_rec in the timeout cycle: completion only
        d_addr = 32'h180; d_rw = 1'b0; d_size = 2'd0; d_wdata = 32'h0;
        exp_q.push_back(mk(1'b0, 1'b0, 2'd0, 32'h0, 32'h180));
        d_req = 1'b1;
        serve("t5", 16);
        d_req = 1'b0;
        check("t5_no_timeout", W'(bus_timeout), W'(0));

        // I line fill 0x40..0x5C locked for 8 beats, then D, then a fresh I grant
        i_addr = 32'h40; i_rw = 1'b0; i_size = 2'd2;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(mk(1'b1, 1'b0, 2'd2, 32'h0, 32'h40 + 32'(4 * k)));
        end
        exp_q.push_back(mk(1'b0, 1'b0, 2'd2, 32'h0, 32'h500));
        exp_q.push_back(mk(1'b1, 1'b0, 2'd2, 32'h0, 32'h60));
        i_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            lat = $urandom_range(1, 4);
            serve($sformatf("t3_beat%0d", k), lat);
            i_addr = i_addr + 32'd4;
            if (k == 0) check_gap("t3");
            if (k == 1) begin
                d_addr = 32'h500; d_rw = 1'b0; d_size = 2'd2;
                d_req  = 1'b1;
            end
        end
        serve("t3_d", 2);
        d_req = 1'b0;
        serve("t3_i9", 2);
        i_req = 1'b0;

        // slave never answers: abort in GRANT cycle 16, then I is served
        d_addr = 32'h600; d_rw = 1'b0; d_size = 2'd2;
        exp_q.push_back(mk(1'b0, 1'b0, 2'd2, 32'h0, 32'h600));
        d_req = 1'b1;
        wait_grant("t4");
        i_addr = 32'h700; i_rw = 1'b0; i_size = 2'd2;
        exp_q.push_back(mk(1'b1, 1'b0, 2'd2, 32'h0, 32'h700));
        i_req = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge mclk);
            check($sformatf("t4_cyc%0d", k), W'({i_err, d_err, mem_rw_req, bus_timeout}),
                  W'({1'b0, k == 16, 1'b1, 1'b0}));
        end
        @(posedge mclk);
        #1 d_req = 1'b0;
        @(negedge mclk);
        check("t4_after_abort", W'({mem_rw_req, bus_timeout, d_err}), W'(3'b010));
        serve("t4_i", 2);
        i_req = 1'b0;
        check("t4_sticky", W'(bus_timeout), W'(1));

        // async reset during a D word write
        d_addr = 32'h800; d_rw = 1'b1; d_size = 2'd2; d_wdata = 32'hDEADBEEF;
        exp_q.push_back(mk(1'b0, 1'b1, 2'd2, 32'hDEADBEEF, 32'h800));
        d_req = 1'b1;
        wait_grant("t6");
        @(posedge mclk);
        #3 reset = 1'b0;
        #1 check_all_zero("t6_async");
        repeat (2) @(negedge mclk);
        d_req = 1'b0;
        reset = 1'b1;
        @(negedge mclk);
        check("t6_idle", W'({a_state, mem_rw_req}), W'({ARB_IDLE, 1'b0}));
        i_addr = 32'hA00; i_rw = 1'b0; i_size = 2'd2;
        exp_q.push_back(mk(1'b1, 1'b0, 2'd2, 32'h0, 32'hA00));
        i_req = 1'b1;
        serve("t6_fresh", 2);
        i_req = 1'b0;

        // round-robin instance: last_owner=D after reset, so I first; no timeout
        @(posedge mclk);
        #1;
        b_i_addr = 32'h10;
        b_d_addr = 32'h20;
        b_i_req  = 1'b1;
        b_d_req  = 1'b1;
        b_wait_grant("rr1");
        check("rr1_addr", W'(b_mem_address), W'(32'h10));
        @(posedge mclk);
        #1 b_mem_rec = 1'b1;
        @(negedge mclk);
        check("rr1_rec", W'({b_i_rec, b_d_rec}), W'(2'b10));
        @(posedge mclk);
        #1 b_mem_rec = 1'b0;
        b_i_req = 1'b0;
        b_wait_grant("rr2");
        check("rr2_addr", W'(b_mem_address), W'(32'h20));
        saw_err = 1'b0;
        for (int k = 0; k < 1100; k++) begin
            @(negedge mclk);
            if (b_d_err || b_i_err || !b_mem_rw_req) saw_err = 1'b1;
        end
        check("rr2_timeout_disabled", W'({saw_err, b_bus_timeout}), W'(0));
        @(posedge mclk);
        #1 b_mem_rec = 1'b1;
        @(negedge mclk);
        check("rr2_rec", W'({b_i_rec, b_d_rec}), W'(2'b01));
        @(posedge mclk);
        #1 b_mem_rec = 1'b0;
        b_d_req = 1'b0;

        check("scoreboard_empty", W'(exp_q.size()), W'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
